// File: rtl/dmem_responder.sv
// Word-organised data memory for the CPU Memory stage: one request at a time on req/ack,
// a fixed number of wait states, then a committed store or registered load, with error flagging.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);
    localparam logic [3:0]        WAIT_L  = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   idx_ext;
    logic [IDX_W-1:0]    idx;
    logic                acc_err;
    logic                accept;
    logic                ent_resp;

    assign accept   = (state_q == S_IDLE) && req;
    assign ent_resp = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign idx_ext  = {2'b00, addr_q[ADDR_W-1:2]};
    assign idx      = idx_ext[IDX_W-1:0];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (idx_ext >= DEPTH_L);

    // state register and control counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= WAIT_L;
            end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (ent_resp) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= '0;
                end else if (!we_q) begin
                    rdata_q <= mem[idx];
                end
            end
        end
    end

    // Every request passes through WAIT, so WAIT=0 still spends one cycle there and the
    // ack lands WAIT+1 edges after acceptance.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack  = 1'b0;
        err  = 1'b0;
        busy = (state_q != S_IDLE);
        if (state_q == S_RESP) begin
            ack = 1'b1;
            err = err_q;
        end
    end

    // request fields captured at acceptance; not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // storage array keeps its contents across reset
    always_ff @(posedge clk) begin
        if (ent_resp && we_q && !acc_err) begin
            mem[idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT=2/3/0) driven by directed vectors,
// one monitor pops expected responses whenever an ack appears.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rstn_v  [3];
    logic        req_v   [3];
    logic        we_v    [3];
    logic [9:0]  addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [31:0] rdata_v [3];
    logic        ack_v   [3];
    logic        err_v   [3];
    logic        busy_v  [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          dut;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(10), .DEPTH(64), .WAIT(2)) u_a (
        .clk(clk), .rst_n(rstn_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]));
    dmem_responder #(.ADDR_W(10), .DEPTH(64), .WAIT(3)) u_b (
        .clk(clk), .rst_n(rstn_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]));
    dmem_responder #(.ADDR_W(10), .DEPTH(256), .WAIT(0)) u_c (
        .clk(clk), .rst_n(rstn_v[2]), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ack(ack_v[2]), .err(err_v[2]), .busy(busy_v[2]));

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 3 : 0;
    endfunction

    // monitor: every ack must match the oldest expected response, including its cycle
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (err_v[d] && !ack_v[d]) begin
                errors++;
                $display("FAIL err_without_ack dut%0d: err=%0b ack=%0b, want err=0", d, err_v[d], ack_v[d]);
            end
            if (ack_v[d]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack dut%0d cyc=%0d: got ack=1, want no ack", d, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.dut != d || e.cyc != cyc || e.err != err_v[d] || rdata_v[d] !== e.rdata) begin
                        errors++;
                        $display("FAIL resp dut%0d: got cyc=%0d err=%0b rdata=%h, want dut%0d cyc=%0d err=%0b rdata=%h",
                                 d, cyc, err_v[d], rdata_v[d], e.dut, e.cyc, e.err, e.rdata);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        int g = 0;
        while (busy_v[d] && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) begin
            checks++; errors++;
            $display("FAIL idle_timeout dut%0d: got busy=1, want busy=0", d);
        end
    endtask

    task automatic issue(input int d, input bit w, input logic [9:0] a, input logic [31:0] wd,
                         input bit e, input logic [31:0] rd, input bit expect_ack);
        exp_t x;
        wait_idle(d);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        x.dut = d; x.err = e; x.rdata = rd; x.cyc = cyc + wait_of(d) + 1;
        if (expect_ack) sb.push_back(x);
    endtask

    initial begin
        exp_t x;
        int g;
        for (int d = 0; d < 3; d++) begin
            rstn_v[d] = 1'b0; req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
        end
        // reset held 3 cycles with a pending store request on instance A
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'h040; wdata_v[0] = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack_v[0] !== 1'b0 || err_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || rdata_v[0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got ack=%b err=%b busy=%b rdata=%h, want 0 0 0 00000000",
                         i, ack_v[0], err_v[0], busy_v[0], rdata_v[0]);
            end
        end
        for (int d = 0; d < 3; d++) rstn_v[d] = 1'b1;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_accept: got busy=%b, want busy=1", busy_v[0]);
        end
        x.dut = 0; x.err = 1'b0; x.rdata = 32'h0; x.cyc = cyc + 3;
        sb.push_back(x);

        // store then back-to-back load of the same word
        issue(0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        issue(0, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        wait_idle(0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rdata_v[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdata_hold: got %h, want deadbeef", rdata_v[0]);
        end

        // misaligned store must not write; out-of-range load flags err
        issue(0, 1'b1, 10'h013, 32'h12345678, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b0, 10'h100, 32'h0, 1'b1, 32'h0, 1'b1);

        // request held high during WAIT and RESP of a store must be ignored
        issue(0, 1'b1, 10'h024, 32'h0BADCAFE, 1'b0, 32'h0, 1'b1);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 10'h020; wdata_v[0] = 32'h0;
        g = 0;
        while (busy_v[0] && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        req_v[0] = 1'b0;
        issue(0, 1'b0, 10'h024, 32'h0, 1'b0, 32'h0BADCAFE, 1'b1);
        wait_idle(0);

        // instance B: reset pulse in the second WAIT cycle discards the store
        issue(1, 1'b1, 10'h030, 32'h00000000, 1'b0, 32'h0, 1'b1);
        issue(1, 1'b1, 10'h030, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #3;
        rstn_v[1] = 1'b0;
        #4;
        rstn_v[1] = 1'b1;
        #1;
        checks++;
        if (busy_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_store_busy: got busy=%b, want 0", busy_v[1]);
        end
        repeat (6) @(posedge clk);
        #1;
        issue(1, 1'b0, 10'h030, 32'h0, 1'b0, 32'h00000000, 1'b1);
        wait_idle(1);

        // instance C: WAIT=0 gives ack one cycle after acceptance
        issue(2, 1'b1, 10'h004, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1);
        issue(2, 1'b0, 10'h004, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
        issue(2, 1'b0, 10'h3FF, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_idle(2);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: got %0d outstanding, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
